fetch_request_tracker: RTL and testbench
========================================

FETCH_REQUEST_TRACKER -- requirements
Module: fetch_request_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning max outstanding fetch requests; legal range 2..8.
REQ-002 SHALL have parameter NUM_UNITS, default 3, meaning fetch sub-unit count; legal range 1..4.
REQ-003 SHALL have parameter ATTR_W, default 34, meaning width of the opaque per-request attribute word.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-006 SHALL have port req_push, input, 1, meaning a new request is issued this cycle.
REQ-007 SHALL have port req_unit_id, input, UW=max(1,clog2(NUM_UNITS)), meaning the target sub-unit.
REQ-008 SHALL have port req_bypass, input, 1, meaning the request completes without unit data (fault or invalid address).
REQ-009 SHALL have port req_attr, input, ATTR_W, meaning the attribute word stored with the request.
REQ-010 SHALL have port full, output, 1, meaning count==DEPTH.
REQ-011 SHALL have port unit_data_valid, input, NUM_UNITS, meaning the per-unit data return strobe.
REQ-012 SHALL have port flush, input, 1, meaning all in-flight requests become stale.
REQ-013 SHALL have port ifence_req, input, 1, meaning an instruction fence is requested.
REQ-014 SHALL have port ifence_start, output, 1, a 1-cycle pulse issued when the fence may reach the cache.
REQ-015 SHALL have port head_valid, input side none, output, 1, meaning the FIFO is non-empty.
REQ-016 SHALL have port head_attr, output, ATTR_W, the head entry attribute.
REQ-017 SHALL have port head_unit_id, output, UW, the head entry unit.
REQ-018 SHALL have port head_bypass, output, 1, the head entry bypass flag.
REQ-019 SHALL have port complete, output, 1, meaning the head retires this cycle.
REQ-020 SHALL have port complete_ok, output, 1, meaning complete & not stale; forwarded to decode.
REQ-021 SHALL have port inflight_count, output, clog2(DEPTH)+1, the current occupancy.
REQ-022 SHALL have port err_overflow, output, 1, sticky: push while full without same-cycle complete.
REQ-023 SHALL have port err_spurious, output, 1, sticky: data_valid from a unit other than the head unit, or with FIFO empty.

Function
REQ-024 Storage SHALL be a DEPTH-entry circular FIFO {attr, unit_id, bypass}, with separate read/write pointers wrapping at DEPTH (non-power-of-2 supported).
REQ-025 head_* SHALL be driven combinationally from the read-pointer entry; value is don't-care when head_valid=0.
REQ-026 complete SHALL = head_valid & (head_bypass | unit_data_valid[head_unit_id]).
REQ-027 Push SHALL be accepted when req_push & (~full | complete); a push while full with complete SHALL retire the head and store the new entry in the same cycle.
REQ-028 A rejected push SHALL not modify the FIFO and SHALL set err_overflow.
REQ-029 count_next SHALL = count + accepted_push - complete; inflight_count registers count_next.
REQ-030 A push into an empty FIFO SHALL not complete the same cycle; minimum latency push to complete is 1 cycle.
REQ-031 stale_count SHALL load count_next on flush; otherwise it SHALL decrement by 1 on complete while non-zero.
REQ-032 complete_ok SHALL = complete & (stale_count==0); requests pushed in the flush cycle SHALL be counted as stale.
REQ-033 Flush SHALL not drop entries; stale entries drain in order through normal completion.
REQ-034 Fence FSM: IDLE -> (ifence_req) WAIT -> (count_next==0) pulse ifence_start, return to IDLE.
REQ-035 ifence_req with count_next==0 SHALL pulse ifence_start in the same cycle and remain IDLE.
REQ-036 ifence_req in WAIT SHALL be absorbed without a second pulse.
REQ-037 err_spurious SHALL be set when any unit_data_valid bit other than the head-unit bit is high, or any bit is high while head_valid=0.

Reset
REQ-038 rst SHALL clear pointers, count, stale_count, fence FSM (IDLE), err_overflow and err_spurious.
REQ-039 After reset, full=0, head_valid=0, complete=0, complete_ok=0, ifence_start=0, inflight_count=0.
REQ-040 Reset mid-operation SHALL discard all entries; in-flight unit_data_valid returns in the following cycle SHALL set err_spurious.

Verification
REQ-041 Scenario: DEPTH=2; push A(unit1), push B(bypass); assert data_valid[1] next cycle -> A completes with complete_ok=1, B completes the following cycle, count goes 2->1->0.
REQ-042 Scenario: FIFO full (2); push C with A completing the same cycle -> count stays 2, err_overflow=0; push with no completion -> err_overflow=1, FIFO unchanged.
REQ-043 Scenario: 2 in flight plus flush with simultaneous push of C -> stale_count=3; next 3 completes have complete_ok=0; 4th has complete_ok=1.
REQ-044 Scenario: ifence_req with 2 in flight -> ifence_start is a single pulse in the cycle the last complete brings count_next to 0; ifence_req with an empty FIFO -> pulse in the same cycle.
REQ-045 Scenario: DEPTH=5, NUM_UNITS=4, 12 push/complete pairs -> pointer wrap verified; head_attr matches push order.
REQ-046 Scenario: data_valid[2] while head targets unit0 -> err_spurious=1, remains set until rst.

Source files
------------

// File: rtl/fetch_request_tracker_if.sv
// Fetch request tracker bus: request issue, unit data returns, flush/fence control
// and the head/status view of the in-flight FIFO.
interface fetch_request_tracker_if #(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned NUM_UNITS = 3,
   parameter int unsigned ATTR_W    = 34
);
   localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic                 req_push;
   logic [UW-1:0]        req_unit_id;
   logic                 req_bypass;
   logic [ATTR_W-1:0]    req_attr;
   logic                 full;
   logic [NUM_UNITS-1:0] unit_data_valid;
   logic                 flush;
   logic                 ifence_req;
   logic                 ifence_start;
   logic                 head_valid;
   logic [ATTR_W-1:0]    head_attr;
   logic [UW-1:0]        head_unit_id;
   logic                 head_bypass;
   logic                 complete;
   logic                 complete_ok;
   logic [CW-1:0]        inflight_count;
   logic                 err_overflow;
   logic                 err_spurious;

   modport master (
      output req_push, req_unit_id, req_bypass, req_attr, unit_data_valid, flush, ifence_req,
      input  full, ifence_start, head_valid, head_attr, head_unit_id, head_bypass, complete,
             complete_ok, inflight_count, err_overflow, err_spurious
   );

   modport slave (
      input  req_push, req_unit_id, req_bypass, req_attr, unit_data_valid, flush, ifence_req,
      output full, ifence_start, head_valid, head_attr, head_unit_id, head_bypass, complete,
             complete_ok, inflight_count, err_overflow, err_spurious
   );
endinterface

// File: rtl/fetch_request_tracker.sv
// In-order tracker of outstanding fetch requests: circular FIFO of per-request
// attributes, flush staleness accounting, fence sequencing and sticky error flags.
module fetch_request_tracker #(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned NUM_UNITS = 3,
   parameter int unsigned ATTR_W    = 34
) (
   input logic                   clk,
   input logic                   rst,
   fetch_request_tracker_if.slave bus
);
   localparam int unsigned UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [ATTR_W-1:0] attr;
      logic [UW-1:0]     unit_id;
      logic              bypass;
   } entry_t;

   typedef enum logic {FenceIdle, FenceWait} fence_state_e;

   entry_t               mem_q [DEPTH];
   logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]        count_q, count_d, stale_q;
   fence_state_e         fence_q;
   logic                 err_overflow_q, err_spurious_q;

   entry_t               head;
   logic                 head_valid, full, complete, push_ok;
   logic [NUM_UNITS-1:0] head_sel;

   // Pointers wrap explicitly so non-power-of-2 depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign head       = mem_q[rd_ptr_q];
   assign head_valid = (count_q != '0);
   assign full       = (count_q == CW'(DEPTH));

   // One-hot of the unit the head waits on; all-zero when empty so any strobe is spurious.
   always_comb begin
      head_sel = '0;
      for (int i = 0; i < int'(NUM_UNITS); i++) begin
         if (head_valid && head.unit_id == UW'(i)) head_sel[i] = 1'b1;
      end
   end

   assign complete = head_valid & (head.bypass | (|(bus.unit_data_valid & head_sel)));
   assign push_ok  = bus.req_push & (~full | complete);
   assign count_d  = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, complete};

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= '{attr: bus.req_attr, unit_id: bus.req_unit_id,
                                        bypass: bus.req_bypass};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         stale_q        <= '0;
         fence_q        <= FenceIdle;
         err_overflow_q <= 1'b0;
         err_spurious_q <= 1'b0;
      end else begin
         if (push_ok)  wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (complete) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_d;
         // Entries pushed in the flush cycle are included via count_d.
         if (bus.flush)                       stale_q <= count_d;
         else if (complete && stale_q != '0) stale_q <= stale_q - CW'(1);
         err_overflow_q <= err_overflow_q | (bus.req_push & ~push_ok);
         err_spurious_q <= err_spurious_q | (|(bus.unit_data_valid & ~head_sel));
         unique case (fence_q)
            FenceIdle: if (bus.ifence_req && count_d != '0) fence_q <= FenceWait;
            FenceWait: if (count_d == '0) fence_q <= FenceIdle;
            default:   fence_q <= FenceIdle;
         endcase
      end
   end

   // The pulse must coincide with the cycle the FIFO drains, so it is decoded from count_d.
   assign bus.ifence_start   = ((fence_q == FenceIdle && bus.ifence_req) || fence_q == FenceWait)
                               && count_d == '0;
   assign bus.full           = full;
   assign bus.head_valid     = head_valid;
   assign bus.head_attr      = head.attr;
   assign bus.head_unit_id   = head.unit_id;
   assign bus.head_bypass    = head.bypass;
   assign bus.complete       = complete;
   assign bus.complete_ok    = complete & (stale_q == '0);
   assign bus.inflight_count = count_q;
   assign bus.err_overflow   = err_overflow_q;
   assign bus.err_spurious   = err_spurious_q;
endmodule

// File: tb/tb_fetch_request_tracker.sv
// Directed bench: vector table on a DEPTH=2 tracker, hand sequences on a DEPTH=5 one.
module tb_fetch_request_tracker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fetch_request_tracker_if #(.DEPTH(2), .NUM_UNITS(3), .ATTR_W(34)) bus2 ();
   fetch_request_tracker_if #(.DEPTH(5), .NUM_UNITS(4), .ATTR_W(34)) bus5 ();

   fetch_request_tracker #(.DEPTH(2), .NUM_UNITS(3), .ATTR_W(34)) u_d2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   fetch_request_tracker #(.DEPTH(5), .NUM_UNITS(4), .ATTR_W(34)) u_d5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5)
   );

   typedef struct {
      logic        push;
      logic [1:0]  unit;
      logic        byp;
      logic [33:0] attr;
      logic [2:0]  udv;
      logic        fl;
      logic        fen;
      logic        e_full, e_hv, e_cmp, e_ok, e_fs;
      logic [1:0]  e_cnt;
      logic        e_ov, e_sp;
      logic [33:0] e_attr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic p, input logic [1:0] u, input logic b,
                               input logic [33:0] a, input logic [2:0] v, input logic fl,
                               input logic fen, input logic full, input logic hv,
                               input logic cmp, input logic ok, input logic fs,
                               input logic [1:0] cnt, input logic ov, input logic sp,
                               input logic [33:0] ea);
      vec_t r;
      r.push = p; r.unit = u; r.byp = b; r.attr = a; r.udv = v; r.fl = fl; r.fen = fen;
      r.e_full = full; r.e_hv = hv; r.e_cmp = cmp; r.e_ok = ok; r.e_fs = fs;
      r.e_cnt = cnt; r.e_ov = ov; r.e_sp = sp; r.e_attr = ea;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus2.req_push = 0; bus2.req_unit_id = '0; bus2.req_bypass = 0; bus2.req_attr = '0;
      bus2.unit_data_valid = '0; bus2.flush = 0; bus2.ifence_req = 0;
      bus5.req_push = 0; bus5.req_unit_id = '0; bus5.req_bypass = 0; bus5.req_attr = '0;
      bus5.unit_data_valid = '0; bus5.flush = 0; bus5.ifence_req = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      idle_inputs();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One cycle on the DEPTH=5 tracker; returns at the negedge for sampling.
   task automatic s5(input logic p, input logic [1:0] u, input logic b, input logic [33:0] a,
                     input logic [3:0] v, input logic fl);
      @(posedge clk); #1;
      bus5.req_push = p; bus5.req_unit_id = u; bus5.req_bypass = b; bus5.req_attr = a;
      bus5.unit_data_valid = v; bus5.flush = fl;
      @(negedge clk);
   endtask

   initial begin
      logic [33:0] mq_attr[$];
      logic [1:0]  mq_unit[$];
      logic [3:0]  v;
      logic        p;

      idle_inputs();
      do_reset();

      // push,unit,byp,attr,udv,flush,fence | full,hv,cmp,ok,fs,cnt,ov,sp,head_attr
      vecs.push_back(mk(0,0,0,34'h0,    3'b000,0,0, 0,0,0,0,0,2'd0,0,0,34'h0));
      vecs.push_back(mk(1,1,0,34'hAAAA, 3'b000,0,0, 0,0,0,0,0,2'd0,0,0,34'h0));
      vecs.push_back(mk(1,0,1,34'hBBBB, 3'b000,0,0, 0,1,0,0,0,2'd1,0,0,34'hAAAA));
      vecs.push_back(mk(0,0,0,34'h0,    3'b010,0,0, 1,1,1,1,0,2'd2,0,0,34'hAAAA));
      vecs.push_back(mk(0,0,0,34'h0,    3'b000,0,0, 0,1,1,1,0,2'd1,0,0,34'hBBBB));
      vecs.push_back(mk(1,1,0,34'hA2,   3'b000,0,0, 0,0,0,0,0,2'd0,0,0,34'h0));
      vecs.push_back(mk(1,2,0,34'hB2,   3'b000,0,0, 0,1,0,0,0,2'd1,0,0,34'hA2));
      vecs.push_back(mk(1,0,0,34'hC,    3'b010,0,0, 1,1,1,1,0,2'd2,0,0,34'hA2));
      vecs.push_back(mk(1,0,0,34'hD,    3'b000,0,0, 1,1,0,0,0,2'd2,0,0,34'hB2));
      vecs.push_back(mk(0,0,0,34'h0,    3'b100,0,0, 1,1,1,1,0,2'd2,1,0,34'hB2));
      vecs.push_back(mk(0,0,0,34'h0,    3'b001,0,0, 0,1,1,1,0,2'd1,1,0,34'hC));
      vecs.push_back(mk(0,0,0,34'h0,    3'b000,0,1, 0,0,0,0,1,2'd0,1,0,34'h0));
      vecs.push_back(mk(1,0,0,34'hE,    3'b000,0,0, 0,0,0,0,0,2'd0,1,0,34'h0));
      vecs.push_back(mk(1,1,1,34'hF,    3'b000,0,1, 0,1,0,0,0,2'd1,1,0,34'hE));
      vecs.push_back(mk(0,0,0,34'h0,    3'b001,0,1, 1,1,1,1,0,2'd2,1,0,34'hE));
      vecs.push_back(mk(0,0,0,34'h0,    3'b000,0,0, 0,1,1,1,1,2'd1,1,0,34'hF));
      vecs.push_back(mk(0,0,0,34'h0,    3'b000,0,0, 0,0,0,0,0,2'd0,1,0,34'h0));
      vecs.push_back(mk(0,0,0,34'h0,    3'b001,0,0, 0,0,0,0,0,2'd0,1,0,34'h0));
      vecs.push_back(mk(0,0,0,34'h0,    3'b000,0,0, 0,0,0,0,0,2'd0,1,1,34'h0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         bus2.req_push = vecs[i].push; bus2.req_unit_id = vecs[i].unit;
         bus2.req_bypass = vecs[i].byp; bus2.req_attr = vecs[i].attr;
         bus2.unit_data_valid = vecs[i].udv; bus2.flush = vecs[i].fl;
         bus2.ifence_req = vecs[i].fen;
         @(negedge clk);
         chk($sformatf("v%0d.full", i), 64'(bus2.full), 64'(vecs[i].e_full));
         chk($sformatf("v%0d.head_valid", i), 64'(bus2.head_valid), 64'(vecs[i].e_hv));
         chk($sformatf("v%0d.complete", i), 64'(bus2.complete), 64'(vecs[i].e_cmp));
         chk($sformatf("v%0d.complete_ok", i), 64'(bus2.complete_ok), 64'(vecs[i].e_ok));
         chk($sformatf("v%0d.ifence_start", i), 64'(bus2.ifence_start), 64'(vecs[i].e_fs));
         chk($sformatf("v%0d.count", i), 64'(bus2.inflight_count), 64'(vecs[i].e_cnt));
         chk($sformatf("v%0d.err_overflow", i), 64'(bus2.err_overflow), 64'(vecs[i].e_ov));
         chk($sformatf("v%0d.err_spurious", i), 64'(bus2.err_spurious), 64'(vecs[i].e_sp));
         if (vecs[i].e_hv)
            chk($sformatf("v%0d.head_attr", i), 64'(bus2.head_attr), 64'(vecs[i].e_attr));
      end

      // Flush with a simultaneous push: three stale completions, then a good one.
      do_reset();
      s5(1, 2'd0, 0, 34'h100, 4'b0000, 0);
      s5(1, 2'd1, 0, 34'h101, 4'b0000, 0);
      s5(1, 2'd2, 0, 34'h102, 4'b0000, 1);
      chk("flush.count", 64'(bus5.inflight_count), 64'd2);
      s5(1, 2'd3, 0, 34'h103, 4'b0001, 0);
      chk("stale1.cmp", 64'(bus5.complete), 64'd1);
      chk("stale1.ok", 64'(bus5.complete_ok), 64'd0);
      s5(0, 2'd0, 0, 34'h0, 4'b0010, 0);
      chk("stale2.cmp", 64'(bus5.complete), 64'd1);
      chk("stale2.ok", 64'(bus5.complete_ok), 64'd0);
      s5(0, 2'd0, 0, 34'h0, 4'b0100, 0);
      chk("stale3.cmp", 64'(bus5.complete), 64'd1);
      chk("stale3.ok", 64'(bus5.complete_ok), 64'd0);
      s5(0, 2'd0, 0, 34'h0, 4'b1000, 0);
      chk("fresh.attr", 64'(bus5.head_attr), 64'h103);
      chk("fresh.ok", 64'(bus5.complete_ok), 64'd1);
      s5(0, 2'd0, 0, 34'h0, 4'b0000, 0);
      chk("drained.hv", 64'(bus5.head_valid), 64'd0);

      // Twelve overlapped push/complete pairs walk the pointers around DEPTH=5 twice.
      for (int i = 0; i < 14; i++) begin
         p = (i < 12);
         v = (i >= 2) ? (4'b0001 << mq_unit[0]) : 4'b0000;
         s5(p, 2'(i % 4), 0, 34'h200 + 34'(i), v, 0);
         chk($sformatf("wrap%0d.count", i), 64'(bus5.inflight_count), 64'(mq_attr.size()));
         chk($sformatf("wrap%0d.cmp", i), 64'(bus5.complete), 64'(i >= 2));
         if (i >= 2) chk($sformatf("wrap%0d.attr", i), 64'(bus5.head_attr), 64'(mq_attr[0]));
         if (i >= 2) begin
            void'(mq_attr.pop_front());
            void'(mq_unit.pop_front());
         end
         if (p) begin
            mq_attr.push_back(34'h200 + 34'(i));
            mq_unit.push_back(2'(i % 4));
         end
      end

      // Strobe from unit2 while the head waits on unit0: no completion, sticky error.
      s5(1, 2'd0, 0, 34'h300, 4'b0000, 0);
      s5(0, 2'd0, 0, 34'h0, 4'b0100, 0);
      chk("spur.cmp", 64'(bus5.complete), 64'd0);
      chk("spur.pre", 64'(bus5.err_spurious), 64'd0);
      s5(0, 2'd0, 0, 34'h0, 4'b0000, 0);
      chk("spur.set", 64'(bus5.err_spurious), 64'd1);
      s5(0, 2'd0, 0, 34'h0, 4'b0000, 0);
      chk("spur.hold", 64'(bus5.err_spurious), 64'd1);
      chk("spur.entry", 64'(bus5.inflight_count), 64'd1);

      // Reset with an entry in flight; the late return is then spurious.
      s5(1, 2'd1, 0, 34'h301, 4'b0000, 0);
      do_reset();
      s5(0, 2'd0, 0, 34'h0, 4'b0010, 0);
      chk("rst.hv", 64'(bus5.head_valid), 64'd0);
      chk("rst.count", 64'(bus5.inflight_count), 64'd0);
      chk("rst.cmp", 64'(bus5.complete), 64'd0);
      chk("rst.sp_clr", 64'(bus5.err_spurious), 64'd0);
      s5(0, 2'd0, 0, 34'h0, 4'b0000, 0);
      chk("rst.sp_late", 64'(bus5.err_spurious), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
